// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: pattern width, digit glyphs, override patterns
// and segment bit positions for the {a,b,c,d,e,f,g} board ordering.
package seg7_pkg;

  localparam int SEG_WIDTH = 7;

  localparam logic [SEG_WIDTH-1:0] SEG_0 = 7'h77;
  localparam logic [SEG_WIDTH-1:0] SEG_1 = 7'h12;
  localparam logic [SEG_WIDTH-1:0] SEG_2 = 7'h5D;
  localparam logic [SEG_WIDTH-1:0] SEG_3 = 7'h5B;
  localparam logic [SEG_WIDTH-1:0] SEG_4 = 7'h3A;
  localparam logic [SEG_WIDTH-1:0] SEG_5 = 7'h6B;
  localparam logic [SEG_WIDTH-1:0] SEG_6 = 7'h6F;
  localparam logic [SEG_WIDTH-1:0] SEG_7 = 7'h52;
  localparam logic [SEG_WIDTH-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_WIDTH-1:0] SEG_9 = 7'h7B;

  localparam logic [SEG_WIDTH-1:0] SEG_DASH = 7'h08;
  localparam logic [SEG_WIDTH-1:0] SEG_ALL  = 7'h7F;
  localparam logic [SEG_WIDTH-1:0] SEG_OFF  = 7'h00;

  // a=top, b=upper-left, c=upper-right, d=middle, e=lower-left, f=lower-right, g=bottom
  typedef enum logic [2:0] {
    SEG_G = 3'd0,
    SEG_F = 3'd1,
    SEG_E = 3'd2,
    SEG_D = 3'd3,
    SEG_C = 3'd4,
    SEG_B = 3'd5,
    SEG_A = 3'd6
  } seg_idx_e;

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational BCD digit to segment-pattern lookup; codes 10-15 map to a dash
// and raise invalid.
module bcd_seg_lut
  import seg7_pkg::*;
(
  input  logic [3:0]           bcd,
  output logic [SEG_WIDTH-1:0] pattern,
  output logic                 invalid
);

  always_comb begin
    pattern = SEG_DASH;
    invalid = 1'b0;
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: begin
        pattern = SEG_DASH;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bcd_seven_seg_decoder.sv
// Registered BCD-to-seven-segment decoder with held digit, lamp-test and
// blanking overrides, and a registered invalid-code flag.
module bcd_seven_seg_decoder
  import seg7_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           bcd,
  input  logic                 load,
  input  logic                 lamp_test,
  input  logic                 blank,
  output logic [SEG_WIDTH-1:0] seg,
  output logic                 err
);

  logic [3:0]           digit_p0;
  logic [3:0]           eff_digit;
  logic [SEG_WIDTH-1:0] pattern;
  logic                 invalid;
  logic [SEG_WIDTH-1:0] seg_p1;
  logic                 err_p1;

  // Loading bypasses the held register so the new digit shows with one-cycle latency
  assign eff_digit = load ? bcd : digit_p0;

  bcd_seg_lut u_lut (
    .bcd     (eff_digit),
    .pattern (pattern),
    .invalid (invalid)
  );

  // Stage p0 -> p1: held digit capture and override mux into the output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_p0 <= 4'd0;
      seg_p1   <= SEG_OFF;
      err_p1   <= 1'b0;
    end else begin
      if (load)
        digit_p0 <= bcd;
      if (lamp_test)
        seg_p1 <= SEG_ALL;
      else if (blank)
        seg_p1 <= SEG_OFF;
      else
        seg_p1 <= pattern;
      err_p1 <= invalid;
    end
  end

  assign seg = seg_p1;
  assign err = err_p1;

endmodule

// File: tb/tb_bcd_seven_seg_decoder.sv
// Bench for bcd_seven_seg_decoder: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the display.
module tb_bcd_seven_seg_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] bcd;
  logic       load;
  logic       lamp_test;
  logic       blank;
  logic [6:0] seg;
  logic       err;

  int n_cmp;
  int n_bad;

  // reference glyphs indexed by digit value
  logic [6:0] glyph [10];
  int         m_held;
  logic [6:0] m_seg;
  logic       m_err;

  bcd_seven_seg_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd       (bcd),
    .load      (load),
    .lamp_test (lamp_test),
    .blank     (blank),
    .seg       (seg),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // apply one cycle of inputs, advance the model, compare both outputs
  task automatic step(input string tag, input logic r, input int d, input logic ld,
                      input logic lt, input logic bl);
    int eff;
    @(negedge clk);
    rst_n     = r;
    bcd       = 4'(d);
    load      = ld;
    lamp_test = lt;
    blank     = bl;
    @(posedge clk);
    if (!r) begin
      m_held = 0;
      m_seg  = 7'h00;
      m_err  = 1'b0;
    end else begin
      eff = ld ? d : m_held;
      if (ld) m_held = d;
      m_err = (eff > 9);
      if (lt)            m_seg = 7'h7F;
      else if (bl)       m_seg = 7'h00;
      else if (eff > 9)  m_seg = 7'h08;
      else               m_seg = glyph[eff];
    end
    #1;
    check_val({tag, "_seg"}, {1'b0, seg}, {1'b0, m_seg});
    check_val({tag, "_err"}, {7'b0, err}, {7'b0, m_err});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    glyph = '{7'h77, 7'h12, 7'h5D, 7'h5B, 7'h3A, 7'h6B, 7'h6F, 7'h52, 7'h7F, 7'h7B};
    m_held = 0;
    m_seg  = 7'h00;
    m_err  = 1'b0;
    rst_n = 1'b0; bcd = 4'd0; load = 1'b0; lamp_test = 1'b0; blank = 1'b0;

    // reset dominates load and lamp_test
    step("rst0", 1'b0, 8, 1'b1, 1'b1, 1'b0);
    step("rst1", 1'b0, 8, 1'b1, 1'b1, 1'b0);
    check_val("rst_seg_const", {1'b0, seg}, 8'h00);
    step("rel", 1'b1, 8, 1'b0, 1'b0, 1'b0);
    check_val("rel_seg_const", {1'b0, seg}, 8'h77);

    for (int i = 0; i < 16; i++)
      step("sweep", 1'b1, i, 1'b1, 1'b0, 1'b0);
    check_val("sweep_last_err", {7'b0, err}, 8'h01);

    step("hold_ld", 1'b1, 5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step("hold", 1'b1, int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    check_val("hold_seg_const", {1'b0, seg}, 8'h6B);

    step("ov_ld3", 1'b1, 3, 1'b1, 1'b0, 1'b0);
    step("ov_lt",  1'b1, 0, 1'b0, 1'b1, 1'b0);
    step("ov_bl",  1'b1, 0, 1'b0, 1'b0, 1'b1);
    step("ov_both",1'b1, 0, 1'b0, 1'b1, 1'b1);
    step("ov_drop",1'b1, 0, 1'b0, 1'b0, 1'b0);
    check_val("ov_drop_const", {1'b0, seg}, 8'h5B);

    step("bl_ld9", 1'b1, 9, 1'b1, 1'b0, 1'b1);
    step("bl_off", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check_val("bl_off_const", {1'b0, seg}, 8'h7B);

    step("lt_ld6", 1'b1, 6, 1'b1, 1'b1, 1'b0);
    step("lt_off", 1'b1, 1, 1'b0, 1'b0, 1'b0);

    step("mr_ld2", 1'b1, 2, 1'b1, 1'b0, 1'b0);
    step("mr_rst", 1'b0, 7, 1'b1, 1'b0, 1'b0);
    step("mr_rel", 1'b1, 7, 1'b0, 1'b0, 1'b0);
    check_val("mr_rel_const", {1'b0, seg}, 8'h77);

    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 39) != 0),
           int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
